// File: rtl/multdiv_iter.sv
// Iterative multiplier/divider working one bit per cycle on operand magnitudes,
// followed by a one-cycle sign fix-up. Private adder, valid/ready request and response.
module multdiv_iter #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       op_i,
    input  logic [1:0]       signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             data_ind_timing_i,
    input  logic             kill_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_result_o,
    output logic             busy_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StComp, StFixup, StDone} state_e;
    typedef enum logic [1:0] {OpMul = 2'd0, OpMulh = 2'd1, OpDiv = 2'd2, OpRem = 2'd3} op_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic               dit_q, dit_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               dbz_q, dbz_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    // Multiplier (shifted right each step) for MUL/MULH, divisor for DIV/REM
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   result_q, result_d;

    // Request decode
    logic             accept;
    logic             req_sign_a, req_sign_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             req_dbz, dbz_early;

    assign accept     = req_valid_i & req_ready_o & ~kill_i;
    assign req_sign_a = a_i[WIDTH-1] & signed_i[0];
    assign req_sign_b = b_i[WIDTH-1] & signed_i[1];
    // Negating MIN wraps back to MIN, which read unsigned is the wanted magnitude
    assign abs_a      = req_sign_a ? -a_i : a_i;
    assign abs_b      = req_sign_b ? -b_i : b_i;
    assign req_dbz    = (abs_b == '0);
    assign dbz_early  = EARLY_OUT & ~data_ind_timing_i & op_i[1] & req_dbz;

    // Iteration step
    logic               is_mul;
    logic [2*WIDTH-1:0] mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               last_iter, mul_early, comp_last;

    assign is_mul    = ~op_q[1];
    assign mul_sum   = prod_q + (opb_q[0] ? mcand_q : '0);
    assign rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign div_diff  = {1'b0, rem_shift} - {2'b00, opb_q};
    assign last_iter = (cnt_q == CntW'(1));
    assign mul_early = EARLY_OUT & ~dit_q & ((opb_q >> 1) == '0);
    assign comp_last = last_iter | (is_mul & mul_early);

    // Sign fix-up
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign prod_fix = (sign_a_q ^ sign_b_q) ? -prod_q : prod_q;
    assign quo_fix  = ((sign_a_q ^ sign_b_q) & ~dbz_q) ? -quo_q : quo_q;
    assign rem_fix  = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; kill overrides everything including the response handshake
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = dbz_early ? StDone : StComp;
            StComp:  if (comp_last) state_d = StFixup;
            StFixup: state_d = StDone;
            StDone:  if (rsp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (kill_i) begin
            state_d = StIdle;
        end
    end

    // Output logic
    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        busy_o      = 1'b1;
        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            StDone:  rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign rsp_result_o = result_q;

    // Datapath next-state
    always_comb begin
        op_d     = op_q;
        dit_d    = dit_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dbz_d    = dbz_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        opb_d    = opb_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d     = op_e'(op_i);
                    dit_d    = data_ind_timing_i;
                    sign_a_d = req_sign_a;
                    sign_b_d = req_sign_b;
                    dbz_d    = req_dbz;
                    cnt_d    = CntW'(WIDTH);
                    prod_d   = '0;
                    mcand_d  = {{WIDTH{1'b0}}, abs_a};
                    opb_d    = abs_b;
                    quo_d    = abs_a;
                    rem_d    = '0;
                    if (dbz_early) begin
                        result_d = (op_i == OpRem) ? a_i : '1;
                    end
                end
            end
            StComp: begin
                cnt_d = cnt_q - CntW'(1);
                if (is_mul) begin
                    prod_d  = mul_sum;
                    mcand_d = mcand_q << 1;
                    opb_d   = opb_q >> 1;
                end else if (div_diff[WIDTH+1]) begin
                    // Trial subtract went negative: restore
                    rem_d = rem_shift;
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = div_diff[WIDTH:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end
            end
            StFixup: begin
                unique case (op_q)
                    OpMul:  result_d = prod_fix[WIDTH-1:0];
                    OpMulh: result_d = prod_fix[2*WIDTH-1:WIDTH];
                    OpDiv:  result_d = quo_fix;
                    OpRem:  result_d = rem_fix;
                endcase
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OpMul;
            dit_q    <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dbz_q    <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            opb_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            dit_q    <= dit_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dbz_q    <= dbz_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            opb_q    <= opb_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed bench for multdiv_iter at WIDTH=32: results, latencies, handshake, kill and reset.
module tb_multdiv_iter;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [1:0]   op;
        logic [1:0]   sg;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         dit;
        logic [W-1:0] exp;
        logic [7:0]   lat;
    } vec_t;

    localparam vec_t MulVecs [8] = '{
        '{2'd0, 2'd3, 32'd7,          32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 8'd34},
        '{2'd1, 2'd3, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 8'd34},
        '{2'd1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 8'd34},
        '{2'd1, 2'd1, 32'hFFFF_FFFF, 32'd2,         1'b1, 32'hFFFF_FFFF, 8'd34},
        '{2'd0, 2'd0, 32'd9,          32'd1,         1'b0, 32'd9,         8'd3},
        '{2'd0, 2'd0, 32'd9,          32'd1,         1'b1, 32'd9,         8'd34},
        '{2'd1, 2'd0, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'd1,         8'd19},
        '{2'd0, 2'd3, 32'hFFFF_FFFF, 32'd5,         1'b0, 32'hFFFF_FFFB, 8'd5}
    };

    localparam vec_t DivVecs [7] = '{
        '{2'd2, 2'd3, 32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFD, 8'd34},
        '{2'd3, 2'd3, 32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFF, 8'd34},
        '{2'd2, 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 8'd34},
        '{2'd3, 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         8'd34},
        '{2'd2, 2'd0, 32'd100,        32'd7,         1'b0, 32'd14,        8'd34},
        '{2'd3, 2'd0, 32'd100,        32'd7,         1'b0, 32'd2,         8'd34},
        '{2'd2, 2'd0, 32'hFFFF_FFF9, 32'd2,         1'b0, 32'h7FFF_FFFC, 8'd34}
    };

    localparam vec_t DbzVecs [7] = '{
        '{2'd2, 2'd0, 32'd5,          32'd0, 1'b0, 32'hFFFF_FFFF, 8'd1},
        '{2'd3, 2'd0, 32'd5,          32'd0, 1'b0, 32'd5,         8'd1},
        '{2'd2, 2'd0, 32'd5,          32'd0, 1'b1, 32'hFFFF_FFFF, 8'd34},
        '{2'd3, 2'd0, 32'd5,          32'd0, 1'b1, 32'd5,         8'd34},
        '{2'd3, 2'd3, 32'hFFFF_FFFB, 32'd0, 1'b0, 32'hFFFF_FFFB, 8'd1},
        '{2'd3, 2'd3, 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFB, 8'd34},
        '{2'd2, 2'd3, 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 8'd34}
    };

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid_i = 1'b0;
    logic         req_ready_o;
    logic [1:0]   op_i = '0;
    logic [1:0]   signed_i = '0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         data_ind_timing_i = 1'b0;
    logic         kill_i = 1'b0;
    logic         rsp_valid_o;
    logic         rsp_ready_i = 1'b0;
    logic [W-1:0] rsp_result_o;
    logic         busy_o;

    int vectors = 0;
    int miscompares = 0;

    multdiv_iter #(
        .WIDTH    (W),
        .EARLY_OUT(1'b1)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .op_i             (op_i),
        .signed_i         (signed_i),
        .a_i              (a_i),
        .b_i              (b_i),
        .data_ind_timing_i(data_ind_timing_i),
        .kill_i           (kill_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_result_o     (rsp_result_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle, then scramble the operand inputs.
    task automatic issue(input logic [1:0] op, input logic [1:0] sg, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic dit);
        op_i              = op;
        signed_i          = sg;
        a_i               = a;
        b_i               = b;
        data_ind_timing_i = dit;
        req_valid_i       = 1'b1;
        step();
        req_valid_i       = 1'b0;
        op_i              = 2'($urandom);
        signed_i          = 2'($urandom);
        a_i               = $urandom;
        b_i               = $urandom;
        data_ind_timing_i = 1'($urandom);
    endtask

    // Cycles after the accept cycle until rsp_valid_o, bounded.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (rsp_valid_o !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [1:0] sg, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic dit, output int lat,
                         output logic [W-1:0] res, output logic idle_after);
        issue(op, sg, a, b, dit);
        wait_rsp(lat);
        res = rsp_result_o;
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        idle_after = (req_ready_o === 1'b1) && (rsp_valid_o === 1'b0) && (busy_o === 1'b0);
    endtask

    task automatic test_reset();
        vectors++;
        if (req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset req_ready: got %b, want 1", req_ready_o);
        end
        vectors++;
        if (rsp_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset rsp_valid: got %b, want 0", rsp_valid_o);
        end
        vectors++;
        if (rsp_result_o !== '0) begin
            miscompares++;
            $display("FAIL reset rsp_result: got %h, want 0", rsp_result_o);
        end
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset busy: got %b, want 0", busy_o);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset idle_after_release: ready=%b busy=%b, want 1/0",
                     req_ready_o, busy_o);
        end
    endtask

    task automatic test_mul();
        int lat;
        logic [W-1:0] res;
        logic idle;
        for (int i = 0; i < 8; i++) begin
            do_op(MulVecs[i].op, MulVecs[i].sg, MulVecs[i].a, MulVecs[i].b, MulVecs[i].dit,
                  lat, res, idle);
            vectors++;
            if (res !== MulVecs[i].exp) begin
                miscompares++;
                $display("FAIL mul[%0d] result: got %h, want %h", i, res, MulVecs[i].exp);
            end
            vectors++;
            if (lat != int'(MulVecs[i].lat)) begin
                miscompares++;
                $display("FAIL mul[%0d] latency: got %0d, want %0d", i, lat, MulVecs[i].lat);
            end
            vectors++;
            if (!idle) begin
                miscompares++;
                $display("FAIL mul[%0d] idle_after_rsp: got 0, want 1", i);
            end
        end
    endtask

    task automatic test_div();
        int lat;
        logic [W-1:0] res;
        logic idle;
        for (int i = 0; i < 7; i++) begin
            do_op(DivVecs[i].op, DivVecs[i].sg, DivVecs[i].a, DivVecs[i].b, DivVecs[i].dit,
                  lat, res, idle);
            vectors++;
            if (res !== DivVecs[i].exp) begin
                miscompares++;
                $display("FAIL div[%0d] result: got %h, want %h", i, res, DivVecs[i].exp);
            end
            vectors++;
            if (lat != int'(DivVecs[i].lat)) begin
                miscompares++;
                $display("FAIL div[%0d] latency: got %0d, want %0d", i, lat, DivVecs[i].lat);
            end
            vectors++;
            if (!idle) begin
                miscompares++;
                $display("FAIL div[%0d] idle_after_rsp: got 0, want 1", i);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        logic [W-1:0] res;
        logic idle;
        for (int i = 0; i < 7; i++) begin
            do_op(DbzVecs[i].op, DbzVecs[i].sg, DbzVecs[i].a, DbzVecs[i].b, DbzVecs[i].dit,
                  lat, res, idle);
            vectors++;
            if (res !== DbzVecs[i].exp) begin
                miscompares++;
                $display("FAIL dbz[%0d] result: got %h, want %h", i, res, DbzVecs[i].exp);
            end
            vectors++;
            if (lat != int'(DbzVecs[i].lat)) begin
                miscompares++;
                $display("FAIL dbz[%0d] latency: got %0d, want %0d", i, lat, DbzVecs[i].lat);
            end
            vectors++;
            if (!idle) begin
                miscompares++;
                $display("FAIL dbz[%0d] idle_after_rsp: got 0, want 1", i);
            end
        end
    endtask

    // Response held off for 5 cycles with a pending request, then released; the pending
    // request is accepted only after the handshake.
    task automatic test_back_to_back();
        int lat;
        logic [W-1:0] res;
        issue(2'd0, 2'd3, 32'd7, 32'hFFFF_FFFD, 1'b1);
        wait_rsp(lat);
        vectors++;
        if (lat != 34) begin
            miscompares++;
            $display("FAIL hold latency: got %0d, want 34", lat);
        end
        op_i              = 2'd0;
        signed_i          = 2'd0;
        a_i               = 32'd9;
        b_i               = 32'd1;
        data_ind_timing_i = 1'b0;
        req_valid_i       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'hFFFF_FFEB || req_ready_o !== 1'b0)
            begin
                miscompares++;
                $display("FAIL hold[%0d] stable: valid=%b result=%h ready=%b, want 1/ffffffeb/0",
                         i, rsp_valid_o, rsp_result_o, req_ready_o);
            end
            step();
        end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        vectors++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL hold release_idle: valid=%b ready=%b busy=%b, want 0/1/0",
                     rsp_valid_o, req_ready_o, busy_o);
        end
        step();
        req_valid_i = 1'b0;
        wait_rsp(lat);
        res = rsp_result_o;
        vectors++;
        if (lat != 3 || res !== 32'd9) begin
            miscompares++;
            $display("FAIL b2b second_op: latency=%0d result=%h, want 3/00000009", lat, res);
        end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_kill();
        int lat;
        logic [W-1:0] res;
        logic idle;
        logic seen;
        issue(2'd2, 2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        repeat (9) step();
        kill_i = 1'b1;
        step();
        kill_i = 1'b0;
        vectors++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL kill idle_next: valid=%b ready=%b busy=%b, want 0/1/0",
                     rsp_valid_o, req_ready_o, busy_o);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid_o !== 1'b0) seen = 1'b1;
            step();
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL kill no_response: got a response, want none");
        end
        // Request with kill in the same cycle is dropped
        op_i        = 2'd0;
        signed_i    = 2'd0;
        a_i         = 32'd3;
        b_i         = 32'd3;
        req_valid_i = 1'b1;
        kill_i      = 1'b1;
        step();
        req_valid_i = 1'b0;
        kill_i      = 1'b0;
        vectors++;
        if (busy_o !== 1'b0 || req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL kill drop_req: busy=%b ready=%b, want 0/1", busy_o, req_ready_o);
        end
        do_op(2'd2, 2'd0, 32'd100, 32'd7, 1'b0, lat, res, idle);
        vectors++;
        if (res !== 32'd14 || lat != 34 || !idle) begin
            miscompares++;
            $display("FAIL kill next_op: result=%h latency=%0d idle=%b, want 0000000e/34/1",
                     res, lat, idle);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [W-1:0] res;
        logic idle;
        issue(2'd0, 2'd0, 32'd5, 32'd3, 1'b1);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || busy_o !== 1'b0 ||
            rsp_result_o !== '0) begin
            miscompares++;
            $display("FAIL rst_mid outputs: ready=%b valid=%b busy=%b result=%h, want 1/0/0/0",
                     req_ready_o, rsp_valid_o, busy_o, rsp_result_o);
        end
        #2;
        rst_n = 1'b1;
        step();
        do_op(2'd0, 2'd0, 32'd5, 32'd3, 1'b1, lat, res, idle);
        vectors++;
        if (res !== 32'd15 || lat != 34 || !idle) begin
            miscompares++;
            $display("FAIL rst_mid next_op: result=%h latency=%0d idle=%b, want 0000000f/34/1",
                     res, lat, idle);
        end
    endtask

    initial begin
        repeat (3) step();
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_kill();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, got %0d vectors, want completion", vectors);
        $fatal(1, "bench timeout");
    end

endmodule
